// File: rtl/booth_arb_pkg.sv
// Shared types and widths for the Booth multiplier arbiter.
// The round-robin option is selected with the BOOTH_ARB_RR_EN macro in booth_mul_arb.
package booth_arb_pkg;

    localparam int OPW        = 8;
    localparam int PRDW       = 16;
    localparam int MUL_CYCLES = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/booth_mul_arb_if.sv
// Bundle of the requester, response and multiplier-side signals of booth_mul_arb.
// slave is the arbiter view; master is the surrounding clients plus booth_8x8.
interface booth_mul_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import booth_arb_pkg::*;

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [OPW*NREQ-1:0] req_mc;
    logic [OPW*NREQ-1:0] req_mp;
    logic                resp_valid;
    logic                resp_ready;
    logic [PRDW-1:0]     resp_prd;
    logic [IDW-1:0]      resp_id;
    logic                mul_start;
    logic [OPW-1:0]      mul_mc;
    logic [OPW-1:0]      mul_mp;
    logic                mul_busy;
    logic [PRDW-1:0]     mul_prd;

    modport slave (
        input  req_valid, req_mc, req_mp, resp_ready, mul_busy, mul_prd,
        output req_ready, resp_valid, resp_prd, resp_id, mul_start, mul_mc, mul_mp
    );

    modport master (
        output req_valid, req_mc, req_mp, resp_ready, mul_busy, mul_prd,
        input  req_ready, resp_valid, resp_prd, resp_id, mul_start, mul_mc, mul_mp
    );

endinterface

// File: rtl/booth_arb_pick.sv
// Combinational winner selection: first valid requester scanning upward from i_ptr, wrapping.
// With i_ptr held at zero this degenerates to lowest-index-wins fixed priority.
module booth_arb_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW:0] w_sum;
    logic [IDW:0] w_pos;

    // rotating scan; the first hit wins and later hits are ignored
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDW+1)'(k);
            w_pos = (w_sum >= (IDW+1)'(NREQ)) ? (w_sum - (IDW+1)'(NREQ)) : w_sum;
            if (!o_any && i_req_valid[w_pos[IDW-1:0]]) begin
                o_any                    = 1'b1;
                o_grant[w_pos[IDW-1:0]]  = 1'b1;
                o_idx                    = w_pos[IDW-1:0];
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arb.sv
// Shares one sequential booth_8x8 among NREQ requesters and returns tagged products.
// Define BOOTH_ARB_RR_EN for round-robin priority; otherwise the lowest index always wins.
module booth_mul_arb
    import booth_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    booth_mul_arb_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_LAUNCH = LAUNCH;
    localparam logic [1:0] S_WAIT   = WAIT;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0]      r_state;
    logic            r_mul_start;
    logic [OPW-1:0]  r_mul_mc;
    logic [OPW-1:0]  r_mul_mp;
    logic            r_resp_valid;
    logic [PRDW-1:0] r_resp_prd;
    logic [IDW-1:0]  r_id;

    logic [IDW-1:0]  w_ptr;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_hs;

    booth_arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req_valid (bus.req_valid),
        .i_ptr       (w_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_hs          = (r_state == S_IDLE) && w_any;
    assign bus.req_ready = (r_state == S_IDLE) ? w_grant : '0;

`ifdef BOOTH_ARB_RR_EN
    logic [IDW-1:0] r_ptr;

    // priority pointer moves to the requester just after each winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : (w_idx + 1'b1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // sequencer: accept, pulse start, catch the one-cycle product, hold the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mul_start  <= 1'b0;
            r_mul_mc     <= '0;
            r_mul_mp     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_prd   <= '0;
            r_id         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_mul_mc    <= bus.req_mc[int'(w_idx)*OPW +: OPW];
                        r_mul_mp    <= bus.req_mp[int'(w_idx)*OPW +: OPW];
                        r_id        <= w_idx;
                        r_mul_start <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    r_mul_start <= 1'b0;
                    r_state     <= S_WAIT;
                end
                // booth_8x8 keeps shifting after it finishes, so prd is good only now
                S_WAIT: begin
                    if (!bus.mul_busy) begin
                        r_resp_prd   <= bus.mul_prd;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_state      <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state      <= S_RESP;
                    end
                end
                default: begin
                    r_mul_start  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mul_start  = r_mul_start;
    assign bus.mul_mc     = r_mul_mc;
    assign bus.mul_mp     = r_mul_mp;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_prd   = r_resp_prd;
    assign bus.resp_id    = r_id;

endmodule

// File: tb/tb_booth_mul_arb.sv
// Directed bench for booth_mul_arb with a behavioural stand-in for booth_8x8.
// Expectations follow BOOTH_ARB_RR_EN when the bench is built with it.
module tb_booth_mul_arb;
    import booth_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    booth_mul_arb_if #(.NREQ(4), .IDW(2)) bus();

    booth_mul_arb #(.NREQ(4), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // multiplier stand-in: busy for MUL_CYCLES cycles after start, product valid for one cycle, then drifts
    logic [3:0]  m_cnt  = 4'd0;
    logic        m_busy = 1'b0;
    logic [15:0] m_prd  = 16'h0000;
    logic [7:0]  m_mc   = 8'h00;
    logic [7:0]  m_mp   = 8'h00;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            m_cnt  <= 4'(MUL_CYCLES - 1);
            m_busy <= 1'b1;
            m_prd  <= 16'hA5A5;
            m_mc   <= bus.mul_mc;
            m_mp   <= bus.mul_mp;
        end else if (m_busy && m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
            m_prd <= {m_prd[14:0], m_prd[15]};
        end else if (m_busy) begin
            m_busy <= 1'b0;
            m_prd  <= $signed({{8{m_mc[7]}}, m_mc}) * $signed({{8{m_mp[7]}}, m_mp});
        end else begin
            m_prd <= {m_prd[14:0], m_prd[15]} ^ 16'h0001;
        end
    end

    assign bus.mul_busy = m_busy;
    assign bus.mul_prd  = m_prd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] mc, input logic [7:0] mp);
        bus.req_valid[id]        = 1'b1;
        bus.req_mc[8*id +: 8]    = mc;
        bus.req_mp[8*id +: 8]    = mp;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(bus.req_ready),  32'd0);
        check({tag, "_mul_start"},  32'(bus.mul_start),  32'd0);
        check({tag, "_mul_mc"},     32'(bus.mul_mc),     32'd0);
        check({tag, "_mul_mp"},     32'(bus.mul_mp),     32'd0);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_prd"},   32'(bus.resp_prd),   32'd0);
        check({tag, "_resp_id"},    32'(bus.resp_id),    32'd0);
    endtask

    // cycle 0 handshake, returns positioned in cycle 1
    task automatic launch(input int id, input logic [7:0] mc, input logic [7:0] mp, input string tag);
        bus.req_valid = 4'b0000;
        set_req(id, mc, mp);
        #1;
        check({tag, "_grant"}, 32'(bus.req_ready), 32'(4'b0001 << id));
        step(1);
        bus.req_valid = 4'b0000;
        check({tag, "_start"}, 32'(bus.mul_start), 32'd1);
        check({tag, "_mc"},    32'(bus.mul_mc),    32'(mc));
        check({tag, "_mp"},    32'(bus.mul_mp),    32'(mp));
        check({tag, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic run_one(input int id, input logic [7:0] mc, input logic [7:0] mp,
                           input logic [15:0] exp_prd, input string tag);
        launch(id, mc, mp, tag);
        for (int c = 2; c <= 10; c++) begin
            step(1);
            check({tag, "_early_valid"}, 32'(bus.resp_valid), 32'd0);
            check({tag, "_start_low"},   32'(bus.mul_start),  32'd0);
        end
        step(1);
        check({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_prd"},   32'(bus.resp_prd),   32'(exp_prd));
        check({tag, "_id"},    32'(bus.resp_id),    32'(id));
        step(1);
        check({tag, "_done"},  32'(bus.resp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        int exp_g;
        bus.req_valid  = 4'b0000;
        bus.req_mc     = 32'h0000_0000;
        bus.req_mp     = 32'h0000_0000;
        bus.resp_ready = 1'b1;

        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // single request from requester 2: -3 * 5
        run_one(2, 8'hFD, 8'h05, 16'hFFF1, "single");

        // all four requesters valid continuously
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'h7F, 8'h7F);
        for (int g = 0; g < 5; g++) begin
`ifdef BOOTH_ARB_RR_EN
            exp_g = g % 4;
`else
            exp_g = 0;
`endif
            #1;
            check("all_grant", 32'(bus.req_ready), 32'(4'b0001 << exp_g));
            step(11);
            check("all_valid", 32'(bus.resp_valid), 32'd1);
            check("all_prd",   32'(bus.resp_prd),   32'h3F01);
            check("all_id",    32'(bus.resp_id),    32'(exp_g));
            step(1);
        end
        bus.req_valid = 4'b0000;
        step(14);

        // backpressure: response held for 20 cycles with everyone requesting
        bus.resp_ready = 1'b0;
        launch(1, 8'h0A, 8'hF6, "bp");
        step(10);
        check("bp_valid", 32'(bus.resp_valid), 32'd1);
        check("bp_prd",   32'(bus.resp_prd),   32'hFF9C);
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            check("bp_hold_prd",   32'(bus.resp_prd),   32'hFF9C);
            check("bp_hold_id",    32'(bus.resp_id),    32'd1);
            check("bp_hold_ready", 32'(bus.req_ready),  32'd0);
            check("bp_hold_start", 32'(bus.mul_start),  32'd0);
        end
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;
        step(1);
        check("bp_release", 32'(bus.resp_valid), 32'd0);

        // product window: -7 * -9 must be taken in the first not-busy cycle
        run_one(0, 8'hF9, 8'hF7, 16'h003F, "window");

        // reset pulsed during WAIT, then 3 * 4
        launch(0, 8'h05, 8'h06, "midrst");
        step(4);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        step(1);
        rst = 1'b0;
        step(1);
        run_one(1, 8'h03, 8'h04, 16'h000C, "after_rst");

        // pointer wrap: pointer at 3 after a grant to 2, then 3 and 0 compete
        do_reset();
        run_one(2, 8'h02, 8'h03, 16'h0006, "wrap_pre");
        set_req(3, 8'h11, 8'h02);
        set_req(0, 8'hFF, 8'hFF);
        #1;
`ifdef BOOTH_ARB_RR_EN
        exp_g = 3;
`else
        exp_g = 0;
`endif
        check("wrap_grant1", 32'(bus.req_ready), 32'(4'b0001 << exp_g));
        step(11);
        check("wrap_id1",  32'(bus.resp_id),  32'(exp_g));
        check("wrap_prd1", 32'(bus.resp_prd), (exp_g == 3) ? 32'h0022 : 32'h0001);
        step(1);
        #1;
        check("wrap_grant2", 32'(bus.req_ready), 32'b0001);
        step(11);
        check("wrap_id2",  32'(bus.resp_id),  32'd0);
        check("wrap_prd2", 32'(bus.resp_prd), 32'h0001);
        bus.req_valid = 4'b0000;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
